jpeg_cone_pipe: RTL and testbench
=================================

# jpeg_cone_pipe

Pipelined, multi-lane, parametrised version of the JPEG timing-cone logic function. It evaluates the cone function independently on each of `LANES` 6-bit input vectors, splits the evaluation across `STAGES` register stages, and moves data with valid/ready flow control. A per-lane optional inversion mode and a saturating count of asserted result bits are provided for datapath checking. The block sits between the JPEG coefficient front end and the timing-characterisation capture logic.

## Interface
- `LANES`, 4, number of independent 6-bit lanes (1..16)
- `STAGES`, 2, pipeline register stages (1, 2 or 3; other values are illegal)
- `CNT_W`, 16, width of the ones counter (4..32)

- `clk`  in  1  single clock; all state updates on its rising edge
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  input beat valid
- `in_ready`  out  1  block accepts a beat this cycle
- `in_data`  in  6*LANES  lane i occupies bits [6i+5:6i]; bit k of a lane is term b_k
- `invert`  in  1  sampled with the beat; inverts that beat's results
- `out_valid`  out  1  result beat valid
- `out_ready`  in  1  downstream accepts the result
- `out_data`  out  LANES  bit i is the lane-i result
- `clr_cnt`  in  1  synchronous clear of `ones_cnt`
- `ones_cnt`  out  CNT_W  saturating count of '1' result bits delivered

## Operation
- Per-lane function:
  - p = ~(b1&b3), q = ~(b2&b0), r = ~(b1&~b5), s = ~(b4&~b3)
  - t = ~(q^s), u = ~(p|q)
  - y = u ^ ~(r^t); result = y ^ invert
- Stage split:
  - STAGES=1: y is computed combinationally and registered once.
  - STAGES=2: stage 1 registers u, r, t; stage 2 registers the result.
  - STAGES=3: stage 1 registers p, q, r, s; stage 2 registers u, r, t; stage 3 registers the result.
- `invert` travels with its beat through every stage.
- Flow control is a global-enable pipeline:
  - en = ~out_valid | out_ready; `in_ready` = en.
  - When en is 1, every stage loads from the previous stage. Each stage's valid bit loads the upstream valid bit; stage 1 loads `in_valid`.
  - When en is 0, all stages hold.
  - Bubbles are not compressed.
- A beat is accepted on `in_valid & in_ready` and delivered on `out_valid & out_ready`.
- Data registers of invalid stages may update freely. `out_data` is only meaningful while `out_valid` is 1.
- Counter:
  - On delivery, `ones_cnt` += popcount(`out_data`), saturating at 2^CNT_W−1. It never wraps.
  - `clr_cnt` without delivery sets the counter to 0.
  - `clr_cnt` together with a delivery sets the counter to popcount(`out_data`): clear first, then add.
- Reset (async assert, synchronous release): all valid bits 0, all data registers 0, `out_data` 0, `ones_cnt` 0.
  - `in_ready` is 0 while `rst` is high and 1 in the first cycle after release.
  - Reset asserted mid-stream discards every in-flight beat. No partial beat appears after release.

## Timing
- Latency: a beat accepted at edge N appears on `out_valid`/`out_data` after edge N+STAGES−1 (registered output), provided en stays 1.
- Throughput: one beat per cycle while `out_ready` is held at 1.
- Backpressure:
  - With `out_valid`=1 and `out_ready`=0, `in_ready` drops combinationally in the same cycle.
  - `out_data` and `invert` alignment stay stable until delivery.
  - No beat is lost or duplicated.
- `in_ready` depends combinationally on `out_ready` and `out_valid` only. It has no dependency on `in_valid`.
- `ones_cnt` updates on the edge that completes the delivery and is visible the next cycle.

## Test plan
- LANES=4, STAGES=2, in_data={0x3F,0x0A,0x05,0x00} (lane3..0), invert=0, out_ready=1 -> out_valid rises one cycle after acceptance, out_data=4'b1001, ones_cnt=2.
- Same beat with invert=1, followed back-to-back by the invert=0 beat -> out_data sequence 4'b0110 then 4'b1001 on consecutive cycles; ones_cnt=4.
- STAGES=3, stream of 8 beats, out_ready toggled 1,0,0,1,... -> `in_ready` low whenever out_valid&~out_ready; all 8 results delivered in order with no drop or duplicate; each result is checked against the reference function.
- CNT_W=4, 8 deliveries of 4'b1111 -> ones_cnt reaches 15 and holds. Then clr_cnt together with a 4'b1001 delivery -> ones_cnt=2. clr_cnt alone -> 0.
- Reset pulse with 2 beats in flight (STAGES=2) -> out_valid=0, out_data=0, ones_cnt=0 immediately; no result appears after release until a new beat is accepted.
- STAGES=1, LANES=1, all 64 input values with random invert and random out_ready -> every delivered bit matches y^invert; latency is 0 cycles after the accepting edge.

Source files
------------

// File: rtl/jpeg_cone_pipe.sv
// Multi-lane pipelined JPEG timing-cone function with global-enable valid/ready flow
// control, per-beat result inversion and a saturating count of delivered '1' bits.
module jpeg_cone_pipe #(
    parameter int unsigned LANES  = 4,
    parameter int unsigned STAGES = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [6*LANES-1:0]    in_data,
    input  logic                  invert,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES-1:0]      out_data,
    input  logic                  clr_cnt,
    output logic [CNT_W-1:0]      ones_cnt
);

    localparam int unsigned PW = $clog2(LANES + 1);
    localparam int unsigned SW = CNT_W + 1;

    // First level of the cone: {p, q, r, s}
    function automatic logic [3:0] f_pqrs(input logic [5:0] b);
        return {~(b[1] & b[3]), ~(b[2] & b[0]), ~(b[1] & ~b[5]), ~(b[4] & ~b[3])};
    endfunction

    // Second level: {u, r, t} from {p, q, r, s}
    function automatic logic [2:0] f_urt(input logic [3:0] pqrs);
        return {~(pqrs[3] | pqrs[2]), pqrs[1], ~(pqrs[2] ^ pqrs[0])};
    endfunction

    // Final level: y from {u, r, t}
    function automatic logic f_y(input logic [2:0] urt);
        return urt[2] ^ ~(urt[1] ^ urt[0]);
    endfunction

    logic                en;
    logic [STAGES-1:0]   vld_q;
    logic [LANES-1:0]    res_q;

    assign en        = ~out_valid | out_ready;
    assign in_ready  = en & ~rst;
    assign out_valid = vld_q[STAGES-1];
    assign out_data  = res_q;

    // Valid chain: all stages advance together, bubbles travel with the data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
        end else if (en) begin
            vld_q <= STAGES'({vld_q, in_valid});
        end
    end

    generate
        if (STAGES == 1) begin : g_s1
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    res_q <= '0;
                end else if (en) begin
                    for (int i = 0; i < LANES; i++) begin
                        res_q[i] <= f_y(f_urt(f_pqrs(in_data[6*i +: 6]))) ^ invert;
                    end
                end
            end
        end else if (STAGES == 2) begin : g_s2
            logic [LANES-1:0][2:0] urt_q;
            logic                  inv_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    urt_q <= '0;
                    inv_q <= 1'b0;
                    res_q <= '0;
                end else if (en) begin
                    inv_q <= invert;
                    for (int i = 0; i < LANES; i++) begin
                        urt_q[i] <= f_urt(f_pqrs(in_data[6*i +: 6]));
                        res_q[i] <= f_y(urt_q[i]) ^ inv_q;
                    end
                end
            end
        end else begin : g_s3
            // Three-stage split; STAGES values other than 1..3 are unsupported
            logic [LANES-1:0][3:0] pqrs_q;
            logic [LANES-1:0][2:0] urt_q;
            logic [1:0]            inv_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pqrs_q <= '0;
                    urt_q  <= '0;
                    inv_q  <= '0;
                    res_q  <= '0;
                end else if (en) begin
                    inv_q <= {inv_q[0], invert};
                    for (int i = 0; i < LANES; i++) begin
                        pqrs_q[i] <= f_pqrs(in_data[6*i +: 6]);
                        urt_q[i]  <= f_urt(pqrs_q[i]);
                        res_q[i]  <= f_y(urt_q[i]) ^ inv_q[1];
                    end
                end
            end
        end
    endgenerate

    logic [PW-1:0]    pop_c;
    logic [CNT_W-1:0] base_c;
    logic [SW-1:0]    sum_c;
    logic             deliver_c;

    // Popcount of the result beat currently on the output
    always_comb begin
        pop_c = '0;
        for (int i = 0; i < LANES; i++) begin
            pop_c = pop_c + PW'(out_data[i]);
        end
    end

    assign deliver_c = out_valid & out_ready;
    assign base_c    = clr_cnt ? '0 : ones_cnt;
    assign sum_c     = {1'b0, base_c} + SW'(pop_c);

    // Clear takes effect before the add when both happen together
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ones_cnt <= '0;
        end else if (deliver_c) begin
            ones_cnt <= sum_c[CNT_W] ? '1 : sum_c[CNT_W-1:0];
        end else if (clr_cnt) begin
            ones_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_jpeg_cone_pipe.sv
// Directed bench for jpeg_cone_pipe: four parameterisations sharing one clock and reset.
module tb_jpeg_cone_pipe;

    logic clk;
    logic rst;

    // A: LANES=4 STAGES=2 CNT_W=16
    logic a_in_valid, a_in_ready, a_invert, a_out_valid, a_out_ready, a_clr_cnt;
    logic [23:0] a_in_data;
    logic [3:0]  a_out_data;
    logic [15:0] a_ones_cnt;
    // B: LANES=4 STAGES=3 CNT_W=16
    logic b_in_valid, b_in_ready, b_invert, b_out_valid, b_out_ready, b_clr_cnt;
    logic [23:0] b_in_data;
    logic [3:0]  b_out_data;
    logic [15:0] b_ones_cnt;
    // C: LANES=4 STAGES=2 CNT_W=4
    logic c_in_valid, c_in_ready, c_invert, c_out_valid, c_out_ready, c_clr_cnt;
    logic [23:0] c_in_data;
    logic [3:0]  c_out_data;
    logic [3:0]  c_ones_cnt;
    // D: LANES=1 STAGES=1 CNT_W=16
    logic d_in_valid, d_in_ready, d_invert, d_out_valid, d_out_ready, d_clr_cnt;
    logic [5:0]  d_in_data;
    logic [0:0]  d_out_data;
    logic [15:0] d_ones_cnt;

    jpeg_cone_pipe #(.LANES(4), .STAGES(2), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .invert(a_invert), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_data(a_out_data), .clr_cnt(a_clr_cnt),
        .ones_cnt(a_ones_cnt));
    jpeg_cone_pipe #(.LANES(4), .STAGES(3), .CNT_W(16)) u_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .invert(b_invert), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_data(b_out_data), .clr_cnt(b_clr_cnt),
        .ones_cnt(b_ones_cnt));
    jpeg_cone_pipe #(.LANES(4), .STAGES(2), .CNT_W(4)) u_c (
        .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .invert(c_invert), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .out_data(c_out_data), .clr_cnt(c_clr_cnt),
        .ones_cnt(c_ones_cnt));
    jpeg_cone_pipe #(.LANES(1), .STAGES(1), .CNT_W(16)) u_d (
        .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready),
        .in_data(d_in_data), .invert(d_invert), .out_valid(d_out_valid),
        .out_ready(d_out_ready), .out_data(d_out_data), .clr_cnt(d_clr_cnt),
        .ones_cnt(d_ones_cnt));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Algebraic normal form of the cone: y = b0b1b2b3 ^ b1~b5 ^ b0b2 ^ b4~b3 ^ 1
    function automatic logic ref_y(input logic [5:0] b);
        return (b[0] & b[1] & b[2] & b[3]) ^ (b[1] & ~b[5]) ^ (b[0] & b[2])
             ^ (b[4] & ~b[3]) ^ 1'b1;
    endfunction

    function automatic logic [3:0] ref4(input logic [23:0] d);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = ref_y(d[6*i +: 6]);
        return r;
    endfunction

    function automatic logic [23:0] bdata(input int k);
        return {6'(k*9 + 1), 6'(k*5 + 2), 6'(k*13), 6'(63 - k*3)};
    endfunction

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    localparam logic [23:0] PAT = {6'h3F, 6'h0A, 6'h05, 6'h00};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [3:0] bq[$];
        int   sent, got, cyc, idx, dlv;
        logic exp_d, exp_nxt, acc, acc_prev;

        {a_in_valid, a_invert, a_clr_cnt, a_in_data} = '0; a_out_ready = 1'b1;
        {b_in_valid, b_invert, b_clr_cnt, b_in_data} = '0; b_out_ready = 1'b1;
        {c_in_valid, c_invert, c_clr_cnt, c_in_data} = '0; c_out_ready = 1'b1;
        {d_in_valid, d_invert, d_clr_cnt, d_in_data} = '0; d_out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_rdy", 32'(a_in_ready), 0);
        check("rst_vld", 32'(a_out_valid), 0);
        check("rst_data", 32'(a_out_data), 0);
        check("rst_cnt", 32'(a_ones_cnt), 0);
        rst = 1'b0;

        // Single beat, STAGES=2 latency and result
        a_in_valid = 1'b1; a_in_data = PAT; a_invert = 1'b0;
        #1 check("t1_rdy", 32'(a_in_ready), 1);
        tick;
        a_in_valid = 1'b0;
        check("t1_lat", 32'(a_out_valid), 0);
        tick;
        check("t1_vld", 32'(a_out_valid), 1);
        check("t1_data", 32'(a_out_data), 32'h9);
        tick;
        check("t1_cnt", 32'(a_ones_cnt), 2);
        check("t1_vld_drop", 32'(a_out_valid), 0);

        // Clear, then inverted beat followed back-to-back by a plain one
        a_clr_cnt = 1'b1;
        tick;
        a_clr_cnt = 1'b0;
        check("t2_clr", 32'(a_ones_cnt), 0);
        a_in_valid = 1'b1; a_in_data = PAT; a_invert = 1'b1;
        tick;
        a_invert = 1'b0;
        tick;
        a_in_valid = 1'b0;
        check("t2_data_inv", 32'(a_out_data), 32'h6);
        tick;
        check("t2_vld2", 32'(a_out_valid), 1);
        check("t2_data_pl", 32'(a_out_data), 32'h9);
        tick;
        check("t2_cnt", 32'(a_ones_cnt), 4);

        // STAGES=3 stream under periodic backpressure
        sent = 0; got = 0; cyc = 0;
        while (got < 8 && cyc < 200) begin
            b_out_ready = (cyc % 3 == 0);
            b_in_valid  = (sent < 8);
            b_in_data   = bdata(sent);
            b_invert    = sent[0];
            #1;
            check("t3_rdy", 32'(b_in_ready), 32'(!(b_out_valid && !b_out_ready)));
            if (b_out_valid && b_out_ready) begin
                if (bq.size() == 0) check("t3_extra_beat", 32'(b_out_data), 32'hFF);
                else                check("t3_data", 32'(b_out_data), 32'(bq.pop_front()));
                got++;
            end
            if (b_in_valid && b_in_ready) begin
                bq.push_back(ref4(b_in_data) ^ {4{b_invert}});
                sent++;
            end
            tick;
            cyc++;
        end
        check("t3_count", 32'(got), 8);
        b_in_valid = 1'b0; b_out_ready = 1'b1;

        // CNT_W=4 saturation, clear-with-delivery, clear alone
        for (int k = 0; k < 8; k++) begin
            c_in_valid = 1'b1; c_in_data = '0;
            tick;
        end
        c_in_valid = 1'b0;
        repeat (3) tick;
        check("t4_sat", 32'(c_ones_cnt), 15);
        c_in_valid = 1'b1; c_in_data = PAT;
        tick;
        c_in_valid = 1'b0;
        tick;
        check("t4_data", 32'(c_out_data), 32'h9);
        c_clr_cnt = 1'b1;
        tick;
        c_clr_cnt = 1'b0;
        check("t4_clr_add", 32'(c_ones_cnt), 2);
        c_clr_cnt = 1'b1;
        tick;
        c_clr_cnt = 1'b0;
        check("t4_clr", 32'(c_ones_cnt), 0);

        // Reset with two beats in flight
        a_in_valid = 1'b1; a_in_data = '0;
        tick;
        tick;
        a_in_valid = 1'b0; a_out_ready = 1'b0;
        #1 check("t5_pre_vld", 32'(a_out_valid), 1);
        rst = 1'b1;
        #1;
        check("t5_vld", 32'(a_out_valid), 0);
        check("t5_data", 32'(a_out_data), 0);
        check("t5_cnt", 32'(a_ones_cnt), 0);
        check("t5_rdy", 32'(a_in_ready), 0);
        tick;
        rst = 1'b0; a_out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1 check("t5_no_ghost", 32'(a_out_valid), 0);
            tick;
        end
        a_in_valid = 1'b1; a_in_data = PAT; a_invert = 1'b1;
        tick;
        a_in_valid = 1'b0; a_invert = 1'b0;
        tick;
        check("t5_post_vld", 32'(a_out_valid), 1);
        check("t5_post_data", 32'(a_out_data), 32'h6);
        tick;

        // STAGES=1 LANES=1 exhaustive sweep with random invert and out_ready
        idx = 0; dlv = 0; cyc = 0; exp_d = 1'b0; acc_prev = 1'b0; exp_nxt = 1'b0;
        while ((idx < 64 || d_out_valid) && cyc < 2000) begin
            d_out_ready = 1'($urandom_range(0, 1));
            d_in_valid  = (idx < 64);
            d_in_data   = 6'(idx);
            d_invert    = 1'($urandom_range(0, 1));
            #1;
            if (acc_prev) check("t6_lat", 32'(d_out_valid), 1);
            if (d_out_valid) check("t6_data", 32'(d_out_data), 32'(exp_d));
            if (d_out_valid && d_out_ready) dlv++;
            acc = d_in_valid && d_in_ready;
            if (acc) begin
                exp_nxt = ref_y(6'(idx)) ^ d_invert;
                idx++;
            end
            tick;
            if (acc) exp_d = exp_nxt;
            acc_prev = acc;
            cyc++;
        end
        check("t6_count", 32'(dlv), 64);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
